branch_scan_controller: RTL and testbench
=========================================

Name: branch_scan_controller

Overview:
- Sequences the program counter during a bracket branch, when the control unit's branch state is active.
- On a `[` taken with a zero accumulator, it steps the PC forward to the matching `]`.
- On a `]` taken with a non-zero accumulator, it steps the PC backward to the matching `[`.
- Tracks nesting depth, drives PC step and direction, and reports completion or error back to the control unit.

Parameters:
- OP_W, 4, width of the instruction opcode input
- OPEN_CODE, 4'h6, opcode value of `[`
- CLOSE_CODE, 4'h7, opcode value of `]`
- DEPTH_W, 8, width of the nesting depth counter
- TIMEOUT, 65535, maximum SCAN cycles (used only with the optional feature)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin a scan; sampled only in IDLE
- dir  input  1  scan direction captured at start; 0 = forward (seek `]`), 1 = backward (seek `[`)
- instruction  input  OP_W  opcode at the current PC, valid combinationally in the same cycle
- pc_at_bound  input  1  PC is at the program boundary (last word forward, address 0 backward)
- pc_step  output  1  PC moves one word this cycle (combinational)
- pc_dir  output  1  direction of pc_step; equals the captured dir
- busy  output  1  high in SCAN and DONE
- done  output  1  one-cycle pulse; the PC rests on the matching bracket
- error  output  1  sticky; unmatched bracket or depth overflow
- depth  output  DEPTH_W  current nesting depth

Behaviour:
- Reset: asynchronous return to IDLE from any state, including mid-scan.
  - depth=0, dir register=0, error=0, done=0, busy=0, pc_step=0.
- States:
  - IDLE: waiting for start.
  - SCAN: stepping the PC and counting brackets.
  - DONE: one cycle, signals completion.
  - ERR: terminal until reset.
- IDLE, start=1:
  - pc_step=1 in the same cycle, to move off the originating bracket.
  - Capture dir; depth<=1; next state SCAN.
  - start=0: stay in IDLE, pc_step=0.
- SCAN, each cycle, classifying `instruction`:
  - "same" bracket is OPEN_CODE when forward, CLOSE_CODE when backward; "match" bracket is the other one.
  - same: depth<=depth+1; pc_step=1.
    - If depth is already all-ones, this is overflow instead: next state ERR, pc_step=0.
  - match with depth==1: depth<=0; pc_step=0; next state DONE. The PC stays on the matching bracket.
  - match with depth>1: depth<=depth-1; pc_step=1.
  - any other opcode: pc_step=1; depth unchanged.
  - pc_at_bound=1 and no terminating match this cycle: pc_step=0; next state ERR.
  - A matching bracket at the boundary completes normally, because the match check has priority over the boundary check.
- DONE:
  - done=1 and busy=1 for exactly one cycle; pc_step=0; then IDLE.
  - depth reads 0.
- ERR:
  - error=1, busy=0, pc_step=0.
  - start is ignored; the state is left only by reset.
- start while busy: ignored; it does not restart or extend the scan.
- pc_dir: driven from the captured dir register in every state; 0 after reset.
- Latency: a match N words away from the origin gives done exactly N+1 cycles after the start cycle (N pc_steps, including the start-cycle step).
- Arithmetic: depth is unsigned; it never decrements below 1 while in SCAN.

Optional Feature:
- Macro: BRANCH_SCAN_TIMEOUT_EN.
- Defined:
  - A 16-bit cycle counter clears on start and increments each SCAN cycle.
  - When the counter reaches TIMEOUT with no terminating event, go to ERR with pc_step=0.
  - A terminating match or a boundary in the same cycle takes priority over the timeout.
- Not defined: no counter is present and TIMEOUT is unused; a scan ends only by match, boundary or overflow.

Test Plan:
- Forward simple: program `[`,`+`,`-`,`]`, start dir=0 at `[` -> pc_step high for 3 cycles, done pulse on cycle 4, PC on `]`, depth 0.
- Backward nested: `[`,`[`,`>`,`]`,`]`, start dir=1 at index 4 -> depth goes 1,2,1, done with PC at index 0 after 5 cycles.
- Unmatched: `[`,`+`,`+` with pc_at_bound on index 2 -> ERR, error=1, pc_step=0; a later start is ignored until reset.
- Overflow: DEPTH_W=2, forward over `[`,`[`,`[`,`[` -> ERR when depth=3 sees another `[`.
- Reset mid-scan: assert reset at depth=2 -> busy, pc_step and depth drop to 0 immediately; a fresh start then runs normally.
- Timeout (macro defined, TIMEOUT=8): 20 non-bracket opcodes -> ERR after 8 SCAN cycles; with the macro undefined the scan continues to a match.

Source files
------------

// File: rtl/branch_scan_controller.sv
// Bracket-branch PC sequencer: walks the PC to the matching bracket while counting nesting depth.
// Optional scan watchdog enabled by defining BRANCH_SCAN_TIMEOUT_EN.
module branch_scan_controller #(
  parameter int              OP_W       = 4,
  parameter logic [OP_W-1:0] OPEN_CODE  = 4'h6,
  parameter logic [OP_W-1:0] CLOSE_CODE = 4'h7,
  parameter int              DEPTH_W    = 8,
  parameter int              TIMEOUT    = 65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               dir,
  input  logic [OP_W-1:0]    instruction,
  input  logic               pc_at_bound,
  output logic               pc_step,
  output logic               pc_dir,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [DEPTH_W-1:0] depth
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE, S_ERR} state_e;

  state_e             state_q, state_d;
  logic               dir_q, dir_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;

  logic [OP_W-1:0] same_code, match_code;
  logic            same_br, match_br, term_match, abort, timeout_hit;

  // "same" deepens the nest, "match" unwinds it; which is which depends on scan direction
  assign same_code  = dir_q ? CLOSE_CODE : OPEN_CODE;
  assign match_code = dir_q ? OPEN_CODE  : CLOSE_CODE;
  assign same_br    = (instruction == same_code);
  assign match_br   = (instruction == match_code);
  assign term_match = match_br && (depth_q == DEPTH_W'(1));
  assign abort      = pc_at_bound || (same_br && (&depth_q)) || timeout_hit;

`ifdef BRANCH_SCAN_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (state_q == S_IDLE && start) timer_d = '0;
    else if (state_q == S_SCAN)     timer_d = timer_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end

  assign timeout_hit = (timer_q == TO_LAST);
`else
  // keeps the parameter referenced when the watchdog is compiled out
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      depth_q <= depth_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    depth_d = depth_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        dir_d   = dir;
        depth_d = DEPTH_W'(1);
        state_d = S_SCAN;
      end
      S_SCAN: begin
        // match on the boundary word still completes: match outranks every abort
        if (term_match) begin
          depth_d = '0;
          state_d = S_DONE;
        end else if (abort) begin
          state_d = S_ERR;
        end else if (same_br) begin
          depth_d = depth_q + DEPTH_W'(1);
        end else if (match_br) begin
          depth_d = depth_q - DEPTH_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_ERR;
    endcase
  end

  always_comb begin
    pc_step = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    error   = 1'b0;
    unique case (state_q)
      S_IDLE:  pc_step = start;
      S_SCAN: begin
        busy    = 1'b1;
        pc_step = !term_match && !abort;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: error = 1'b1;
    endcase
  end

  assign pc_dir = dir_q;
  assign depth  = depth_q;

endmodule

// File: tb/tb_branch_scan_controller.sv
// Directed bench for branch_scan_controller: per-cycle vector table plus program-driven scan sequences.
module tb_branch_scan_controller;
  localparam int         DW  = 2;
  localparam logic [3:0] OPN = 4'h6, CLS = 4'h7, PLS = 4'h2, MIN = 4'h3, GT = 4'h4;

  logic          clk = 1'b0;
  logic          reset = 1'b1, start = 1'b0, dir = 1'b0, pc_at_bound = 1'b0;
  logic [3:0]    instruction = PLS;
  logic          pc_step, pc_dir, busy, done, error;
  logic [DW-1:0] depth;

  always #5 clk = ~clk;

  branch_scan_controller #(
    .OP_W(4), .OPEN_CODE(OPN), .CLOSE_CODE(CLS), .DEPTH_W(DW), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .instruction(instruction),
    .pc_at_bound(pc_at_bound), .pc_step(pc_step), .pc_dir(pc_dir), .busy(busy),
    .done(done), .error(error), .depth(depth)
  );

  int nvec = 0, nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit rst, st, d, bnd;
    logic [3:0] ins;
    bit e_step, e_busy, e_done, e_err, e_pdir, chk_dep;
    int e_dep;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit st, bit d, bit bnd, logic [3:0] ins,
                              bit stp, bit bsy, bit dn, bit er, bit pd, bit cd, int dp);
    vec_t v;
    v.rst = rst; v.st = st; v.d = d; v.bnd = bnd; v.ins = ins;
    v.e_step = stp; v.e_busy = bsy; v.e_done = dn; v.e_err = er; v.e_pdir = pd;
    v.chk_dep = cd; v.e_dep = dp;
    return v;
  endfunction

  logic [3:0] prog [0:63];
  int dtrace [0:63];

  // Drives a program from the bench's own PC model until done/error or the cycle budget runs out
  task automatic run_scan(input int plen, input int origin, input bit d, input int rst_at,
                          output int done_cyc, output int err_cyc, output int pc_fin, output int nsteps);
    int pc;
    pc = origin; done_cyc = -1; err_cyc = -1; nsteps = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      reset = 1'b0;
      start = (c == 0);
      dir = d;
      instruction = prog[pc];
      pc_at_bound = d ? (pc == 0) : (pc == plen - 1);
      #1;
      dtrace[c] = int'(depth);
      if (done && done_cyc < 0) done_cyc = c;
      if (error && err_cyc < 0) err_cyc = c;
      if (c == rst_at) begin
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_step", pc_step, 0);
        chk("rst_mid_depth", depth, 0);
        break;
      end
      if (pc_step) begin
        nsteps++;
        pc = d ? pc - 1 : pc + 1;
        if (pc < 0 || pc > 63) break;
      end
      if (done_cyc >= 0 || err_cyc >= 0) break;
    end
    pc_fin = pc;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  int dc, ec, pf, ns;

  initial begin
    //          rst st d bnd ins  | step busy done err pdir chkdep dep
    tbl.push_back(mk(1, 0, 0, 0, PLS, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, OPN, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, PLS, 1, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, MIN, 1, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, CLS, 0, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, OPN, 0, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, PLS, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, OPN, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, PLS, 1, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, PLS, 0, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, OPN, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, OPN, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, PLS, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, CLS, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, OPN, 0, 1, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, PLS, 0, 1, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, PLS, 0, 0, 0, 0, 1, 1, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rst; start = tbl[i].st; dir = tbl[i].d;
      pc_at_bound = tbl[i].bnd; instruction = tbl[i].ins;
      #1;
      chk($sformatf("v%0d_step", i), pc_step, tbl[i].e_step);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("v%0d_done", i), done, tbl[i].e_done);
      chk($sformatf("v%0d_err", i), error, tbl[i].e_err);
      chk($sformatf("v%0d_pdir", i), pc_dir, tbl[i].e_pdir);
      if (tbl[i].chk_dep) chk($sformatf("v%0d_depth", i), depth, tbl[i].e_dep);
    end
    @(negedge clk); start = 1'b0; reset = 1'b0;

    // backward nested: [ [ > ] ] from index 4
    for (int i = 0; i < 64; i++) prog[i] = PLS;
    prog[0] = OPN; prog[1] = OPN; prog[2] = GT; prog[3] = CLS; prog[4] = CLS;
    run_scan(5, 4, 1'b1, -1, dc, ec, pf, ns);
    chk("bwd_done_cyc", dc, 5);
    chk("bwd_pc", pf, 0);
    chk("bwd_steps", ns, 4);
    chk("bwd_d1", dtrace[1], 1);
    chk("bwd_d2", dtrace[2], 2);
    chk("bwd_d3", dtrace[3], 2);
    chk("bwd_d4", dtrace[4], 1);
    chk("bwd_d5", dtrace[5], 0);

    // overflow: depth 3 is full at DEPTH_W=2
    for (int i = 0; i < 64; i++) prog[i] = PLS;
    prog[0] = OPN; prog[1] = OPN; prog[2] = OPN; prog[3] = OPN; prog[5] = CLS;
    run_scan(6, 0, 1'b0, -1, dc, ec, pf, ns);
    chk("ovf_err_cyc", ec, 4);
    chk("ovf_pc", pf, 3);
    chk("ovf_depth", dtrace[3], 3);
    chk("ovf_busy", busy, 0);
    chk("ovf_step", pc_step, 0);
    pulse_reset();

    // reset mid-scan at depth 2, then a fresh scan
    for (int i = 0; i < 64; i++) prog[i] = PLS;
    prog[0] = OPN; prog[1] = OPN; prog[4] = CLS; prog[5] = CLS;
    run_scan(6, 0, 1'b0, 2, dc, ec, pf, ns);
    chk("rst_mid_pre_depth", dtrace[2], 2);
    run_scan(6, 0, 1'b0, -1, dc, ec, pf, ns);
    chk("rerun_done_cyc", dc, 6);
    chk("rerun_pc", pf, 5);
    chk("rerun_err", ec, -1);

    // long scan: 20 plain opcodes between brackets
    for (int i = 0; i < 64; i++) prog[i] = PLS;
    prog[0] = OPN; prog[21] = CLS;
    run_scan(22, 0, 1'b0, -1, dc, ec, pf, ns);
`ifdef BRANCH_SCAN_TIMEOUT_EN
    chk("long_err_cyc", ec, 9);
    chk("long_done", dc, -1);
    pulse_reset();
`else
    chk("long_done_cyc", dc, 22);
    chk("long_pc", pf, 21);
    chk("long_err", ec, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
